// File: rtl/vram_rect_writer.sv
// Rectangle-fill write engine for port B of the 960x480 background VRAM.
// Clips each command to the VRAM bounds and writes one pixel per granted cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a command, cmd_ready high
//   CLIP   | compute clipped end coordinates, reject empty rectangles
//   FILL   | raster-order writes, one per cycle with wr_allow high
//   DONE   | one-cycle done pulse, back to IDLE
module vram_rect_writer #(
  parameter int VRAM_W  = 960,
  parameter int VRAM_H  = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 9
) (
  input  logic               clk_25mhz,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x,
  input  logic [9:0]         cmd_y,
  input  logic [9:0]         cmd_w,
  input  logic [9:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               wr_allow,
  output logic [ADDR_W-1:0]  vram_addrb,
  output logic [COLOR_W-1:0] vram_dinb,
  output logic               vram_web,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [10:0]       W11   = 11'(VRAM_W);
  localparam logic [10:0]       H11   = 11'(VRAM_H);
  localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(VRAM_W);

  state_t               state, state_n;
  logic [9:0]           x_r, y_r, w_r, h_r;
  logic [9:0]           x_n, y_n, w_n, h_n;
  logic [COLOR_W-1:0]   color_r, color_n;
  logic [10:0]          x_end, y_end, x_end_n, y_end_n;
  logic [10:0]          cx, cy, cx_n, cy_n;
  logic [ADDR_W-1:0]    row_base, row_base_n;
  logic [ADDR_W-1:0]    addr_n;
  logic [COLOR_W-1:0]   din_n;
  logic                 web_n;
  logic [10:0]          sum_x, sum_y;

  assign cmd_ready = (state == S_IDLE) & RST_N;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // 11-bit sums so x+w and y+h never wrap before clipping
  assign sum_x = {1'b0, x_r} + {1'b0, w_r};
  assign sum_y = {1'b0, y_r} + {1'b0, h_r};

  always_comb begin
    state_n    = state;
    x_n        = x_r;
    y_n        = y_r;
    w_n        = w_r;
    h_n        = h_r;
    color_n    = color_r;
    x_end_n    = x_end;
    y_end_n    = y_end;
    cx_n       = cx;
    cy_n       = cy;
    row_base_n = row_base;
    addr_n     = vram_addrb;
    din_n      = vram_dinb;
    web_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          x_n     = cmd_x;
          y_n     = cmd_y;
          w_n     = cmd_w;
          h_n     = cmd_h;
          color_n = cmd_color;
          state_n = S_CLIP;
        end
      end

      S_CLIP: begin
        x_end_n = (sum_x > W11) ? W11 : sum_x;
        y_end_n = (sum_y > H11) ? H11 : sum_y;
        if ((w_r == 10'd0) || (h_r == 10'd0) ||
            ({1'b0, x_r} >= W11) || ({1'b0, y_r} >= H11)) begin
          state_n = S_DONE;
        end else begin
          row_base_n = ADDR_W'(y_r) * PITCH;
          cx_n       = {1'b0, x_r};
          cy_n       = {1'b0, y_r};
          state_n    = S_FILL;
        end
      end

      S_FILL: begin
        // cy reaches y_end once the last pixel is registered; this extra cycle
        // lets that write leave port B before DONE is shown
        if (cy == y_end) begin
          state_n = S_DONE;
        end else if (wr_allow) begin
          web_n  = 1'b1;
          addr_n = row_base + ADDR_W'(cx);
          din_n  = color_r;
          if (cx == (x_end - 11'd1)) begin
            cx_n       = {1'b0, x_r};
            cy_n       = cy + 11'd1;
            row_base_n = row_base + PITCH;
          end else begin
            cx_n = cx + 11'd1;
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      x_r        <= '0;
      y_r        <= '0;
      w_r        <= '0;
      h_r        <= '0;
      color_r    <= '0;
      x_end      <= '0;
      y_end      <= '0;
      cx         <= '0;
      cy         <= '0;
      row_base   <= '0;
      vram_addrb <= '0;
      vram_dinb  <= '0;
      vram_web   <= 1'b0;
    end else begin
      state      <= state_n;
      x_r        <= x_n;
      y_r        <= y_n;
      w_r        <= w_n;
      h_r        <= h_n;
      color_r    <= color_n;
      x_end      <= x_end_n;
      y_end      <= y_end_n;
      cx         <= cx_n;
      cy         <= cy_n;
      row_base   <= row_base_n;
      vram_addrb <= addr_n;
      vram_dinb  <= din_n;
      vram_web   <= web_n;
    end
  end

endmodule
